// File: rtl/tinyfpga_cfg_loader.sv
// tinyfpga_cfg_loader: frames a sync-prefixed byte stream and shifts it MSB-first into the fabric config chain.
// Optional CRC-8 trailer check is compiled in with TINYFPGA_CFG_CRC_EN.
module tinyfpga_cfg_loader #(
    parameter int         CFG_BITS  = 256,
    parameter logic [7:0] SYNC_BYTE = 8'hA5
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] byte_in,
    input  logic       byte_valid,
    output logic       byte_ready,
    output logic       cfg_bit,
    output logic       cfg_shift,
    output logic       cfg_done,
    output logic       cfg_error,
    output logic       fabric_en
);
    localparam int            CW = $clog2(CFG_BITS / 8 + 1);
    localparam logic [CW-1:0] NB = CW'(CFG_BITS / 8);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_SHIFT,
`ifdef TINYFPGA_CFG_CRC_EN
        S_CHECK,
`endif
        S_DONE,
        S_ERROR
    } state_t;

    state_t        r_state, w_state_nx;
    logic [CW-1:0] r_byte_cnt;
    logic [2:0]    r_bit_cnt;
    logic [7:0]    r_shreg;
    logic          w_xfer, w_restart;

    assign w_xfer     = byte_valid && byte_ready;
    assign w_restart  = w_xfer && byte_in == SYNC_BYTE &&
                        (r_state == S_IDLE || r_state == S_DONE || r_state == S_ERROR);
    assign byte_ready = r_state != S_SHIFT;
    assign cfg_shift  = r_state == S_SHIFT;
    assign cfg_bit    = r_shreg[7];
    assign cfg_done   = r_state == S_DONE;
    assign fabric_en  = cfg_done;

`ifdef TINYFPGA_CFG_CRC_EN
    logic [7:0] r_crc;

    function automatic logic [7:0] crc8(input logic [7:0] c, input logic [7:0] d);
        logic [7:0] x;
        x = c ^ d;
        for (int i = 0; i < 8; i++) x = x[7] ? ((x << 1) ^ 8'h07) : (x << 1);
        return x;
    endfunction

    assign cfg_error = r_state == S_ERROR;
`else
    assign cfg_error = 1'b0;
`endif

    always_comb begin
        w_state_nx = r_state;
        case (r_state)
            S_IDLE, S_DONE, S_ERROR: w_state_nx = w_restart ? S_LOAD : r_state;
            S_LOAD:  w_state_nx = w_xfer ? S_SHIFT : S_LOAD;
            S_SHIFT: if (r_bit_cnt == 3'd7)
`ifdef TINYFPGA_CFG_CRC_EN
                w_state_nx = (r_byte_cnt < NB) ? S_LOAD : S_CHECK;
            S_CHECK: if (w_xfer) w_state_nx = (byte_in == r_crc) ? S_DONE : S_ERROR;
`else
                w_state_nx = (r_byte_cnt < NB) ? S_LOAD : S_DONE;
`endif
            default: w_state_nx = S_IDLE;
        endcase
    end

    // Shifting refills with bit 0 so cfg_bit keeps the last shifted bit between bytes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_byte_cnt <= '0;
            r_bit_cnt  <= '0;
            r_shreg    <= '0;
`ifdef TINYFPGA_CFG_CRC_EN
            r_crc      <= '0;
`endif
        end else begin
            r_state <= w_state_nx;
            if (w_restart) begin
                r_byte_cnt <= '0;
`ifdef TINYFPGA_CFG_CRC_EN
                r_crc      <= '0;
`endif
            end
            if (r_state == S_LOAD && w_xfer) begin
                r_shreg    <= byte_in;
                r_byte_cnt <= r_byte_cnt + CW'(1);
                r_bit_cnt  <= '0;
`ifdef TINYFPGA_CFG_CRC_EN
                r_crc      <= crc8(r_crc, byte_in);
`endif
            end else if (r_state == S_SHIFT) begin
                r_shreg   <= {r_shreg[6:0], r_shreg[0]};
                r_bit_cnt <= r_bit_cnt + 3'd1;
            end
        end
    end
endmodule

// File: tb/tb_tinyfpga_cfg_loader.sv
// tb_tinyfpga_cfg_loader: directed stimulus against a queue-based model of the loader (CFG_BITS=16).
// Define TINYFPGA_CFG_CRC_EN to exercise the CRC trailer path.
module tb_tinyfpga_cfg_loader;
    localparam int NB = 2;
`ifdef TINYFPGA_CFG_CRC_EN
    localparam bit CRC_ON = 1'b1;
`else
    localparam bit CRC_ON = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] byte_in = 8'h00;
    logic       byte_valid = 1'b0;
    logic       byte_ready, cfg_bit, cfg_shift, cfg_done, cfg_error, fabric_en;

    tinyfpga_cfg_loader #(.CFG_BITS(16), .SYNC_BYTE(8'hA5)) dut (
        .clk(clk), .rst_n(rst_n), .byte_in(byte_in), .byte_valid(byte_valid),
        .byte_ready(byte_ready), .cfg_bit(cfg_bit), .cfg_shift(cfg_shift),
        .cfg_done(cfg_done), .cfg_error(cfg_error), .fabric_en(fabric_en)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // CRC-8/0x07 by polynomial long division of {crc^d, 8'h00} by x^8+x^2+x+1
    function automatic logic [7:0] crc_upd(input logic [7:0] c, input logic [7:0] d);
        logic [15:0] r;
        r = {c ^ d, 8'h00};
        for (int i = 15; i >= 8; i--) if (r[i]) r = r ^ (16'h0107 << (i - 8));
        return r[7:0];
    endfunction

    // Model: queue of chain bits still to emit; empty queue means a byte can be taken.
    logic q_bits[$];
    logic m_last, m_inframe, m_await, m_done, m_err;
    int   m_cnt;
    logic [7:0] m_crc;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q_bits.delete();
            m_last = 0; m_inframe = 0; m_await = 0; m_done = 0; m_err = 0; m_cnt = 0; m_crc = 0;
        end else if (q_bits.size() > 0) begin
            m_last = q_bits.pop_front();
            if (q_bits.size() == 0 && m_cnt == NB) begin
                m_inframe = 0;
                if (CRC_ON) m_await = 1; else m_done = 1;
            end
        end else if (byte_valid) begin
            if (m_await) begin
                m_await = 0;
                if (byte_in == m_crc) m_done = 1; else m_err = 1;
            end else if (m_inframe) begin
                for (int i = 7; i >= 0; i--) q_bits.push_back(byte_in[i]);
                m_cnt++;
                m_crc = crc_upd(m_crc, byte_in);
            end else if (byte_in == 8'hA5) begin
                m_inframe = 1; m_cnt = 0; m_crc = 0; m_done = 0; m_err = 0;
            end
        end
    end

    int pulses = 0;
    int low_run = 0;
    logic [15:0] chain = 16'h0;

    always @(negedge clk) begin
        chk("byte_ready", 16'(byte_ready), 16'(q_bits.size() == 0));
        chk("cfg_shift", 16'(cfg_shift), 16'(q_bits.size() > 0));
        chk("cfg_bit", 16'(cfg_bit), 16'(q_bits.size() > 0 ? q_bits[0] : m_last));
        chk("cfg_done", 16'(cfg_done), 16'(m_done));
        chk("cfg_error", 16'(cfg_error), 16'(m_err));
        chk("fabric_en", 16'(fabric_en), 16'(m_done));
        if (!rst_n) low_run = 0;
        else if (!byte_ready) low_run++;
        else begin
            if (low_run != 0) chk("ready_low_run", 16'(low_run), 16'd8);
            low_run = 0;
        end
        if (cfg_shift) begin
            pulses++;
            chain = {chain[14:0], cfg_bit};
        end
    end

    task automatic send(input logic [7:0] b);
        logic r;
        byte_in = b;
        byte_valid = 1'b1;
        for (int t = 0; t < 40; t++) begin
            r = byte_ready;
            @(posedge clk);
            if (r) begin
                @(negedge clk);
                byte_valid = 1'b0;
                return;
            end
        end
        n_err++;
        $display("FAIL send_timeout: byte %h not accepted within 40 cycles", b);
        byte_valid = 1'b0;
    endtask

    task automatic frame(input logic [7:0] b0, input logic [7:0] b1);
        send(8'hA5); send(b0); send(b1);
        if (CRC_ON) send(crc_upd(crc_upd(8'h00, b0), b1));
        repeat (12) @(negedge clk);
    endtask

    int p0;

    initial begin
        repeat (3) @(negedge clk);
        chk("rst_ready", 16'(byte_ready), 16'd1);
        chk("rst_outs", {12'd0, cfg_shift, cfg_done, cfg_error, fabric_en}, 16'd0);
        chk("crc_pin_813c", 16'(crc_upd(crc_upd(8'h00, 8'h81), 8'h3C)), 16'h0017);
        #1 rst_n = 1'b1;

        // reset on the 4th shift cycle of the first payload byte
        send(8'hA5); send(8'h81);
        repeat (3) @(negedge clk);
        chk("mid_shift_active", 16'(cfg_shift), 16'd1);
        #2 rst_n = 1'b0;
        #1 chk("async_rst_outs", {12'd0, cfg_shift, cfg_done, cfg_error, fabric_en}, 16'd0);
        repeat (2) @(negedge clk);
        #1 rst_n = 1'b1;
        chk("post_rst_ready", 16'(byte_ready), 16'd1);
        p0 = pulses;
        send(8'h3C);
        repeat (12) @(negedge clk);
        chk("discard_no_shift", 16'(pulses - p0), 16'd0);

        // basic load with a leading discarded byte
        p0 = pulses;
        send(8'h3C);
        frame(8'h81, 8'h3C);
        chk("basic_pulses", 16'(pulses - p0), 16'd16);
        chk("basic_stream", chain, 16'b1000000100111100);
        chk("basic_done", {14'd0, cfg_done, fabric_en}, 16'b11);

        // back-to-back reconfiguration with held byte_valid
        p0 = pulses;
        frame(8'hC3, 8'h5A);
        chk("b2b_pulses", 16'(pulses - p0), 16'd16);
        chk("b2b_stream", chain, 16'hC35A);

        // reconfigure from DONE: fabric_en drops on the sync edge
        chk("pre_reconf_en", 16'(fabric_en), 16'd1);
        send(8'hA5);
        chk("reconf_en_drop", 16'(fabric_en), 16'd0);
        send(8'h00); send(8'hFF);
        if (CRC_ON) send(crc_upd(crc_upd(8'h00, 8'h00), 8'hFF));
        repeat (12) @(negedge clk);
        chk("reconf_stream", chain, 16'b0000000011111111);
        chk("reconf_done", 16'(cfg_done), 16'd1);

        if (CRC_ON) begin
            p0 = pulses;
            send(8'hA5); send(8'h81); send(8'h3C); send(8'h17);
            repeat (4) @(negedge clk);
            chk("crc_pass_pulses", 16'(pulses - p0), 16'd16);
            chk("crc_pass", {14'd0, cfg_done, cfg_error}, 16'b10);
            send(8'hA5); send(8'h81); send(8'h3C); send(8'h18);
            repeat (4) @(negedge clk);
            chk("crc_fail", {14'd0, cfg_error, fabric_en}, 16'b10);
            send(8'hA5);
            chk("crc_err_clear", 16'(cfg_error), 16'd0);
            send(8'h81); send(8'h3C); send(8'h17);
            repeat (4) @(negedge clk);
            chk("crc_recover", {14'd0, cfg_done, cfg_error}, 16'b10);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
